ctz_seq_unit: RTL and testbench
===============================

Name: ctz_seq_unit

Overview:
- Iterative count-trailing-zeros unit for the Zbb bit-manipulation datapath.
- Complements the combinational leading-zero encoder: it scans from the opposite end of the word, LSB first, examining STEP bits per cycle.
- Exits early on the first set bit.
- Sits beside the ALU as a multi-cycle functional unit, with valid/ready handshakes on both input and output.

Parameters:
DATA_WIDTH, 32, operand width; must be a multiple of STEP
STEP, 4, bits examined per scan cycle; power of 2, 1..DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand valid
in_ready  output  1  unit can accept an operand
in_data  input  DATA_WIDTH  operand
in_op  input  1  0=CTZ, 1=CPOP; CPOP applies only with CTZ_CPOP_EN
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  DATA_WIDTH  result, zero-extended count
busy  output  1  high in SCAN and DONE

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk. All state is in registers.
- Reset values:
  - state=IDLE
  - out_valid=0
  - out_data=0
  - busy=0
  - shift register, count and chunk counter all 0
- in_ready = (state==IDLE) & ~rst, combinational.
- IDLE:
  - On in_valid & in_ready: capture in_data into the shift register and in_op into the op register.
  - Clear count and chunk index (chunk index counts 0..DATA_WIDTH/STEP-1).
  - Next state SCAN. Without a handshake, stay in IDLE.
- SCAN, CTZ op, one chunk per cycle; chunk = low STEP bits of the shift register:
  - If chunk != 0: count += index of the lowest set bit in the chunk; next state DONE.
  - Otherwise, if chunk index == DATA_WIDTH/STEP-1: count = DATA_WIDTH; next state DONE.
  - Otherwise: count += STEP; shift register >>= STEP; chunk index++.
- SCAN cycles for CTZ = min(floor(ctz/STEP)+1, DATA_WIDTH/STEP).
- Entering DONE: out_valid=1 and out_data=count are registered on the same edge that leaves SCAN.
- DONE:
  - out_valid, out_data and state hold stable while out_ready=0.
  - On out_ready=1: out_valid clears and the next state is IDLE.
  - The next operand can be accepted no earlier than the cycle after the output handshake; there is no same-cycle turnaround.
- Latency: an operand accepted at edge k shows out_valid=1 after edge k+n, where n = number of SCAN cycles.
- Count width: the internal count is clog2(DATA_WIDTH)+1 bits; upper out_data bits are 0.
- Boundary cases:
  - in_data=0 returns DATA_WIDTH after DATA_WIDTH/STEP scan cycles.
  - MSB-only input returns DATA_WIDTH-1 with the same latency.
- in_valid while busy is ignored. in_ready=0 then, so no operand is lost and the upstream holds it.
- rst asserted in any state, including mid-SCAN or DONE with out_valid high:
  - Next state is IDLE; out_valid=0, out_data=0.
  - The partial result is discarded.
- No X propagation: out_data is defined while out_valid=0; it holds its last value, or 0 after reset.

Optional Feature:
- Macro CTZ_CPOP_EN.
- Defined:
  - in_op=1 selects population count.
  - SCAN always runs all DATA_WIDTH/STEP chunks, with no early exit.
  - Each cycle adds the popcount of the chunk to count and shifts by STEP.
  - Fixed latency DATA_WIDTH/STEP.
  - in_op=0 behaves as CTZ.
- Undefined:
  - in_op is ignored and the registered op is forced to CTZ.
  - No popcount logic is synthesised.

Test Plan:
1. Early exit: in_data=0x00000001, op=0, accepted at edge 0 -> out_valid=1 after edge 1, out_data=0; busy high for 1 cycle before DONE.
2. Zero operand: in_data=0x00000000 -> 8 scan cycles, out_data=32. MSB only: in_data=0x80000000 -> 8 scan cycles, out_data=31.
3. Backpressure: in_data=0x00000100 -> out_valid after 3 scan cycles, out_data=8. With out_ready=0 for 5 cycles: out_data stays 8, in_ready stays 0, and in_valid pulses are ignored. After out_ready=1: in_ready=1 on the next cycle.
4. Reset mid-scan: in_data=0x00010000, rst=1 in the 2nd SCAN cycle -> next cycle IDLE, out_valid=0, out_data=0, in_ready=1. Then in_data=0x00000010 -> out_data=4.
5. Back-to-back operands: feed 0x00000004, 0x00000040 and 0x00004000 with out_ready=1 -> out_data=2, 6, 14 in order; each accept occurs at least one cycle after the previous output handshake.
6. CTZ_CPOP_EN defined: in_data=0xF0F0000F, op=1 -> 8 scan cycles, out_data=12. Same stimulus without the macro -> out_data=0 after 1 scan cycle.

Source files
------------

// File: rtl/ctz_seq_if.sv
// Operand/result handshake bundle for ctz_seq_unit.
// slave: the unit side; master: the producer/consumer side.
interface ctz_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ctz_seq_unit.sv
// Iterative count-trailing-zeros unit: scans STEP bits per cycle from the LSB
// and stops on the first set bit.
// Optional macro CTZ_CPOP_EN adds population count (in_op=1), which always
// scans every chunk. Without it in_op is ignored and only CTZ is built.
module ctz_seq_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 4
) (
  input  logic       clk,
  input  logic       rst,
  ctz_seq_if.slave   io,
  output logic       busy
);
  localparam int NCHUNK = DATA_WIDTH / STEP;
  localparam int CW     = $clog2(DATA_WIDTH) + 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
`ifdef CTZ_CPOP_EN
  logic                  op_q, op_d;
  logic [CW-1:0]         chunk_pop;
`endif

  logic [STEP-1:0] chunk;
  logic [CW-1:0]   lsb_idx;
  logic            last_chunk;

  assign chunk       = sh_q[STEP-1:0];
  assign last_chunk  = (idx_q == IW'(NCHUNK - 1));
  assign io.in_ready = (state_q == IDLE) & ~rst;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign busy         = (state_q != IDLE);

  // Index of the lowest set bit in the current chunk (scan high to low so the lowest wins).
  always_comb begin
    lsb_idx = '0;
    for (int i = STEP - 1; i >= 0; i--)
      if (chunk[i]) lsb_idx = CW'(i);
  end

`ifdef CTZ_CPOP_EN
  // Number of set bits in the current chunk.
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < STEP; i++)
      chunk_pop = chunk_pop + CW'(chunk[i]);
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef CTZ_CPOP_EN
    op_d        = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.in_valid && io.in_ready) begin
          sh_d    = io.in_data;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
`ifdef CTZ_CPOP_EN
          op_d    = io.in_op;
`endif
        end
      end
      SCAN: begin
`ifdef CTZ_CPOP_EN
        if (op_q) begin
          // Popcount never exits early: fixed NCHUNK-cycle latency.
          cnt_d = cnt_q + chunk_pop;
          sh_d  = sh_q >> STEP;
          if (last_chunk) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = DATA_WIDTH'(cnt_d);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else
`endif
        begin
          if (chunk != '0) begin
            cnt_d       = cnt_q + lsb_idx;
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = DATA_WIDTH'(cnt_d);
          end else if (last_chunk) begin
            cnt_d       = CW'(DATA_WIDTH);
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = DATA_WIDTH'(cnt_d);
          end else begin
            cnt_d = cnt_q + CW'(STEP);
            sh_d  = sh_q >> STEP;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        // Result holds until consumed; return to IDLE so the next accept is a cycle later.
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef CTZ_CPOP_EN
      op_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef CTZ_CPOP_EN
      op_q        <= op_d;
`endif
    end
  end
endmodule

// File: tb/tb_ctz_seq_unit.sv
// Directed bench for ctz_seq_unit (DATA_WIDTH=32, STEP=4).
module tb_ctz_seq_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_chk  = 0;
  int   n_pass = 0;

  ctz_seq_if #(.DATA_WIDTH(32)) bus ();

  ctz_seq_unit #(.DATA_WIDTH(32), .STEP(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one operand, measure scan latency, optionally stall the output for
  // hold cycles (pulsing in_valid meanwhile), then consume the result.
  task automatic run_op(input string tag, input logic [31:0] data, input logic op,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int n;
    n = 0;
    bus.out_ready = (hold == 0);
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = data; bus.in_op = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = 32'hDEAD_BEEF;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_data"}, bus.out_data, exp);
    chk({tag, "_inrdy_done"}, {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 32'h0000_0001;
      @(posedge clk); #1;
      chk({tag, "_hold_data"}, bus.out_data, exp);
      chk({tag, "_hold_vld"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_hold_inrdy"}, {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_vld_clr"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_inrdy_after"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_op = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inrdy", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_vld",   {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data",  bus.out_data, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_inrdy_rel", {31'd0, bus.in_ready}, 32'd1);

    run_op("lsb",   32'h0000_0001, 1'b0, 32'd0,  1, 0);
    run_op("zero",  32'h0000_0000, 1'b0, 32'd32, 8, 0);
    run_op("msb",   32'h8000_0000, 1'b0, 32'd31, 8, 0);
    run_op("bp",    32'h0000_0100, 1'b0, 32'd8,  3, 5);
    // pulses during the stall must not have started a new operation
    #1;
    chk("bp_no_ghost", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_no_busy",  {31'd0, busy}, 32'd0);

    // reset during the second SCAN cycle
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 32'h0001_0000; bus.in_op = 1'b0;
    @(posedge clk); #1;                // accept
    bus.in_valid = 1'b0;
    @(posedge clk); #1;                // now in 2nd scan cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mrst_vld",   {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_data",  bus.out_data, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    chk("mrst_inrdy", {31'd0, bus.in_ready}, 32'd1);
    run_op("post_rst", 32'h0000_0010, 1'b0, 32'd4, 2, 0);

    run_op("b2b0", 32'h0000_0004, 1'b0, 32'd2,  1, 0);
    run_op("b2b1", 32'h0000_0040, 1'b0, 32'd6,  2, 0);
    run_op("b2b2", 32'h0000_4000, 1'b0, 32'd14, 4, 0);

`ifdef CTZ_CPOP_EN
    run_op("cpop",   32'hF0F0_000F, 1'b1, 32'd12, 8, 0);
    run_op("cpop_z", 32'h0000_0000, 1'b1, 32'd0,  8, 0);
`else
    run_op("cpop",   32'hF0F0_000F, 1'b1, 32'd0,  1, 0);
`endif
    run_op("ctz_op0", 32'hF0F0_0010, 1'b0, 32'd4, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
